// File: rtl/seg_pipe_adder_if.sv
// rtl/seg_pipe_adder_if.sv - operand/result handshake bundle for seg_pipe_adder
interface seg_pipe_adder_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // producer/consumer side: feeds operands, accepts results
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // adder side
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seg_pipe_adder.sv
// rtl/seg_pipe_adder.sv - segmented pipelined add/sub, one SEG-bit carry segment per stage (optional SEG_PIPE_ADDER_SAT_EN)
module seg_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input logic            clk,
  input logic            rst_n,
  seg_pipe_adder_if.slave bus
);

  localparam int STAGES = (WIDTH / SEG < 1) ? 1 : WIDTH / SEG;
  localparam int LAST   = STAGES - 1;
  // pipe registers sit between stages; keep at least one entry so a
  // single-stage build still has legal array bounds
  localparam int QN     = (STAGES > 1) ? STAGES - 1 : 1;

  // inputs seen by each stage
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_sum [STAGES];
  logic             st_c   [STAGES];
  logic             st_v   [STAGES];
  logic             st_sub [STAGES];

  // per-stage segment add results
  logic [SEG:0]     seg_add [STAGES];
  logic [WIDTH-1:0] nx_sum  [STAGES];
  logic             nx_c    [STAGES];

  // registers between stage s and s+1
  logic [WIDTH-1:0] q_a   [QN];
  logic [WIDTH-1:0] q_b   [QN];
  logic [WIDTH-1:0] q_sum [QN];
  logic             q_c   [QN];
  logic             q_v   [QN];
  logic             q_sub [QN];

  // output registers
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             stall;
  logic [WIDTH-1:0] sum_fin;
  logic             ovf_fin;

  // the whole pipe freezes when the held result is not taken
  assign stall         = out_valid_q && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  // stage 0 takes the operand ports (b inverted for subtract); later stages take the pipe registers
  always_comb begin
    st_a[0]   = bus.a;
    st_b[0]   = bus.sub ? ~bus.b : bus.b;
    st_sum[0] = '0;
    st_c[0]   = bus.sub;
    st_v[0]   = bus.in_valid;
    st_sub[0] = bus.sub;
    for (int s = 1; s < STAGES; s++) begin
      st_a[s]   = q_a[s-1];
      st_b[s]   = q_b[s-1];
      st_sum[s] = q_sum[s-1];
      st_c[s]   = q_c[s-1];
      st_v[s]   = q_v[s-1];
      st_sub[s] = q_sub[s-1];
    end
  end

  // stage s adds its own segment and merges it into the completed lower segments
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      seg_add[s] = {1'b0, st_a[s][s*SEG +: SEG]} + {1'b0, st_b[s][s*SEG +: SEG]}
                   + {{SEG{1'b0}}, st_c[s]};
      nx_c[s]    = seg_add[s][SEG];
      nx_sum[s]  = st_sum[s];
      nx_sum[s][s*SEG +: SEG] = seg_add[s][SEG-1:0];
    end
  end

  // overflow on the raw sum; saturation only changes what lands on the sum port
  always_comb begin
    ovf_fin = (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &&
              (nx_sum[LAST][WIDTH-1] != st_a[LAST][WIDTH-1]);
`ifdef SEG_PIPE_ADDER_SAT_EN
    sum_fin = nx_sum[LAST];
    if (!st_sub[LAST] && nx_c[LAST]) begin
      sum_fin = '1;
    end else if (st_sub[LAST] && !nx_c[LAST]) begin
      sum_fin = '0;
    end
`else
    sum_fin = nx_sum[LAST];
`endif
  end

  // inter-stage registers advance together unless stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QN; i++) begin
        q_a[i]   <= '0;
        q_b[i]   <= '0;
        q_sum[i] <= '0;
        q_c[i]   <= 1'b0;
        q_v[i]   <= 1'b0;
        q_sub[i] <= 1'b0;
      end
    end else if (!stall) begin
      for (int i = 0; i < STAGES - 1; i++) begin
        q_a[i]   <= st_a[i];
        q_b[i]   <= st_b[i];
        q_sum[i] <= nx_sum[i];
        q_c[i]   <= nx_c[i];
        q_v[i]   <= st_v[i];
        q_sub[i] <= st_sub[i];
      end
    end
  end

  // final stage: result registers only load on a real slot so they hold across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= st_v[LAST];
      if (st_v[LAST]) begin
        sum_q  <= sum_fin;
        cout_q <= nx_c[LAST];
        ovf_q  <= ovf_fin;
      end
    end
  end

endmodule

// File: tb/tb_seg_pipe_adder.sv
// tb/tb_seg_pipe_adder.sv - self-checking bench for seg_pipe_adder (WIDTH=32, SEG=8)
module tb_seg_pipe_adder;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_pipe_adder_if #(.WIDTH(W)) bus ();

  seg_pipe_adder #(.WIDTH(W), .SEG(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [10];

  int n_pass  = 0;
  int n_total = 0;

  logic [33:0] exp_q [$];
  int          rx = 0;
  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [33:0] prev_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] sat_adj(input logic [31:0] s, input logic c, input logic sub);
`ifdef SEG_PIPE_ADDER_SAT_EN
    if (!sub && c) return 32'hFFFF_FFFF;
    if (sub && !c) return 32'h0;
`endif
    return s;
  endfunction

  // reference: plain 33-bit add, native subtract with a>=b as no-borrow
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [32:0] r;
    logic [31:0] s;
    logic        c;
    logic        o;
    if (!sub) begin
      r = {1'b0, a} + {1'b0, b};
      s = r[31:0];
      c = r[32];
      o = (a[31] == b[31]) && (s[31] != a[31]);
    end else begin
      s = a - b;
      c = (a >= b);
      o = (a[31] != b[31]) && (s[31] != a[31]);
    end
    return {c, o, sat_adj(s, c, sub)};
  endfunction

  // output-side scoreboard and stall checks
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (prev_stall) begin
        chk("stall_valid_hold", bus.out_valid, 1);
        chk("stall_data_hold", {bus.cout, bus.ovf, bus.sum}, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL extra_result: got %0h expected none", {bus.cout, bus.ovf, bus.sum});
        end else begin
          chk($sformatf("result%0d", rx), {bus.cout, bus.ovf, bus.sum}, exp_q.pop_front());
        end
        rx++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = {bus.cout, bus.ovf, bus.sum};
    end
  end

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [33:0] exp, input string tag);
    int lat;
    bus.out_ready = 1'b1;
    bus.a = a; bus.b = b; bus.sub = sub; bus.in_valid = 1'b1;
    #1;
    chk($sformatf("%s_in_ready", tag), bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s_latency", tag), lat, 4);
    chk($sformatf("%s_result", tag), {bus.cout, bus.ovf, bus.sum}, exp);
    @(posedge clk); #1;
  endtask

  task automatic drive(input int n, input bit rnd_ready, input bit stream,
                       output int acc, output int cyc);
    logic [31:0] da, db;
    logic        ds;
    acc = 0; cyc = 0;
    da = $urandom; db = $urandom; ds = 1'($urandom_range(0, 1));
    while (acc < n && cyc < 2000) begin
      bus.a = da; bus.b = db; bus.sub = ds; bus.in_valid = 1'b1;
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (stream && acc == 3) chk("stream_not_yet_valid", bus.out_valid, 0);
      if (stream && acc == 4) chk("stream_first_valid", bus.out_valid, 1);
      if (bus.in_ready) begin
        exp_q.push_back(model(da, db, ds));
        acc++;
        da = $urandom; db = $urandom; ds = 1'($urandom_range(0, 1));
      end
      cyc++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int acc;
    int cyc;
    int wait_n;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_sum", bus.sum, 0);
    chk("reset_cout", bus.cout, 0);
    chk("reset_ovf", bus.ovf, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].sub,
              {vecs[i].cout, vecs[i].ovf, sat_adj(vecs[i].sum, vecs[i].cout, vecs[i].sub)},
              $sformatf("vec%0d", i));
    end

    // result registers hold through bubbles
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bubble_hold", {bus.out_valid, bus.sum}, {1'b0, sat_adj(32'h0100_0100, 1'b0, 1'b0)});

    // streaming at full throughput
    exp_q.delete(); rx = 0; prev_stall = 1'b0; mon_en = 1'b1;
    drive(100, 1'b0, 1'b1, acc, cyc);
    chk("stream_accept_cycles", cyc, 100);
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    chk("stream_rx_minus1", rx, 99);
    @(posedge clk); @(negedge clk); #1;
    chk("stream_rx_all", rx, 100);
    chk("stream_queue_empty", exp_q.size(), 0);

    // random backpressure
    rx = 0;
    @(posedge clk); #1;
    drive(200, 1'b1, 1'b0, acc, cyc);
    bus.out_ready = 1'b1;
    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 50) begin
      @(posedge clk); #1;
      wait_n++;
    end
    @(negedge clk); #1;
    chk("bp_accepted", acc, 200);
    chk("bp_queue_empty", exp_q.size(), 0);
    chk("bp_rx_count", rx, 200);
    mon_en = 1'b0;

    // reset with the pipe full and the output stalled
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.a = 32'h10 * (i + 1); bus.b = 32'h20; bus.sub = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("prereset_valid", bus.out_valid, 1);
    chk("prereset_sum", bus.sum, 32'h30);
    chk("prereset_in_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", bus.out_valid, 0);
    chk("midreset_sum", bus.sum, 0);
    chk("midreset_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_one(32'h0000_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b0, 32'h0001_0000}, "postreset");
    @(posedge clk); #1;
    chk("postreset_no_stale", bus.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_pipe_adder.md
# seg_pipe_adder

- Parametrised, pipelined successor to the team's single-bit half adder.
- Adds or subtracts two WIDTH-bit operands in SEG-bit carry segments, one segment per pipeline stage.
- Uses a valid/ready handshake on both sides, sustains one result per cycle, and stalls cleanly under backpressure.
- Sits in the PageRank datapath in front of the rank accumulators, where a single-cycle 32-bit carry chain misses timing.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SEG.
- SEG, 8, segment width; STAGES = WIDTH/SEG, with a minimum of 1.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: a+b; 1: a−b, computed as a + ~b + 1.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of the MSB segment; for sub, 1 means no borrow.
- ovf  output  1  signed two's-complement overflow.

## Operation
- Accept: a, b and sub are accepted on an edge where in_valid && in_ready.
  - b is inverted when sub=1.
  - Carry-in of segment 0 is set to sub.
- Stage s (0..STAGES−1) adds segment s of a and b' plus the carry from stage s−1.
  - It registers the SEG-bit partial sum and the carry.
  - It also registers the unconsumed upper segments of a and b', the completed lower sum segments, sub, and a valid bit.
- The final stage drives sum, cout and ovf from registers. There is no combinational path from operand inputs to outputs.
- ovf = (a[MSB] == b'[MSB]) && (sum_raw[MSB] != a[MSB]). It is computed on the unsaturated sum.
- Stall:
  - stall = out_valid && !out_ready.
  - When stall=1, every stage register holds its value.
  - When stall=0, all stages advance together.
  - in_ready = !stall, which is combinational from out_ready and the final valid.
- Bubbles: empty slots propagate as valid=0. Stage data for an empty slot is don't-care, but sum, cout and ovf must hold their last value while out_valid=0.
- Reset (any time, including mid-transfer):
  - All valid bits, sum, cout and ovf clear to 0 immediately.
  - In-flight operations are discarded.
  - in_ready returns high.
- Corner values:
  - WIDTH == SEG gives one stage and latency 1.
  - Arithmetic wraps modulo 2^WIDTH unless the Configuration feature is enabled.

## Timing
- Latency: an operand set accepted at edge k produces out_valid=1 after edge k+STAGES−1 (STAGES cycles). With WIDTH=32 and SEG=8, latency is 4 cycles.
- Throughput: one transaction per cycle while out_ready=1.
- Output handshake:
  - A result transfers on an edge where out_valid && out_ready.
  - The result is held stable while out_valid && !out_ready.
- Simultaneous accept and output: allowed in the same cycle when out_ready=1, which is full throughput.
- Backpressure: if out_ready falls while the pipe is full, in_ready falls in the same cycle. No transaction is dropped or duplicated.
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.

## Configuration
- SEG_PIPE_ADDER_SAT_EN defined: unsigned saturation in the final stage.
  - For add with cout=1, sum is forced to all-ones.
  - For sub with cout=0 (borrow), sum is forced to 0.
  - cout and ovf still report raw carry and overflow.
- SEG_PIPE_ADDER_SAT_EN undefined: sum wraps modulo 2^WIDTH. Port list and latency are identical in both builds.

## Test plan
All scenarios use WIDTH=32 and SEG=8.

- Reset then single add: a=0x0000_00FF, b=0x0000_0001, sub=0 → after 4 cycles out_valid=1, sum=0x0000_0100, cout=0, ovf=0.
- Full carry ripple: a=0xFFFF_FFFF, b=1 →
  - sum=0x0000_0000, cout=1 without macro.
  - sum=0xFFFF_FFFF, cout=1 with SEG_PIPE_ADDER_SAT_EN.
- Subtract and overflow:
  - a=5, b=7, sub=1 → sum=0xFFFF_FFFE, cout=0, ovf=0; with macro, sum=0.
  - a=0x7FFF_FFFF, b=1, sub=0 → sum=0x8000_0000, ovf=1.
- Streaming: 100 back-to-back random transactions with out_ready=1 → 100 results in order, one per cycle from cycle 4, matching a reference model.
- Backpressure: random out_ready (50%) over 200 random transactions →
  - in_ready == !(out_valid && !out_ready) every cycle.
  - No loss or duplication.
  - sum/cout/ovf stable while stalled.
- Mid-operation reset: assert rst_n=0 with 3 transactions in flight → out_valid=0 and sum=0 immediately, before the next edge. After release, the first new transaction emerges 4 cycles after acceptance with no stale result.
